uart_rx: RTL and testbench

- 8N1 UART receiver; the receive-side counterpart of the data-memory UART transmitter.
- Deserialises an asynchronous serial line into bytes and buffers them in a small FIFO.
- Presents bytes to the CPU-side MMIO logic via a valid/ready pop interface.
- Sits beside DataMemory's UART TX. The bench also uses it as a loopback monitor on uart_tx_wire to check console output.

---
 rtl/uart_rx_pkg.sv | 16 +
 rtl/uart_rx_fifo.sv | 49 ++++
 rtl/uart_rx.sv | 136 +++++++++++++
 tb/tb_uart_rx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

    localparam int UART_DATA_W               = 8;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 868;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through FIFO with wrap-bit pointers; head holds the last popped
// entry while empty.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] last;
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? last : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            last   <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                last   <= mem[rd_ptr[AW-1:0]];
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver feeding a small FIFO with a valid/ready pop port.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   uart_rx_wire,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic                   rx_busy,
    output logic                   frame_err,
    output logic                   overrun,
    output logic                   parity_err
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    uart_rx_state_e         state, state_nxt;
    logic                   rx_meta, rxs;
    logic [CW-1:0]          cnt;
    logic [2:0]             idx;
    logic [UART_DATA_W-1:0] sh;
    logic                   tick, shift_en, push, fe_set, par_bad;
    logic                   empty, full, pop_req;

    assign tick     = (cnt == LAST);
    assign pop_req  = rx_valid && rx_ready;
    assign rx_valid = !empty;
    assign rx_busy  = (state != IDLE);

`ifdef UART_RX_PARITY_EN
    logic pe_set;
`endif

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        push      = 1'b0;
        fe_set    = 1'b0;
`ifdef UART_RX_PARITY_EN
        pe_set    = 1'b0;
`endif
        case (state)
            IDLE:  if (!rxs) state_nxt = START;
            // A start bit that is high again at mid-bit is a glitch.
            START: if (cnt == HALF) state_nxt = rxs ? IDLE : DATA;
            DATA: if (tick) begin
                shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
                if (idx == 3'd7) state_nxt = PARITY;
`else
                if (idx == 3'd7) state_nxt = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick) begin
                pe_set    = (rxs != ^sh);
                state_nxt = STOP;
            end
`endif
            STOP: if (tick) begin
                if (rxs) begin
                    push      = !par_bad;
                    state_nxt = IDLE;
                end else begin
                    fe_set    = 1'b1;
                    state_nxt = BREAK;
                end
            end
            BREAK:   if (rxs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta   <= 1'b1;
            rxs       <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_meta   <= uart_rx_wire;
            rxs       <= rx_meta;
            state     <= state_nxt;
            cnt       <= (state_nxt != state || tick) ? '0 : cnt + CW'(1);
            if (state == START) idx <= '0;
            if (shift_en) begin
                sh  <= {rxs, sh[UART_DATA_W-1:1]};
                idx <= idx + 3'd1;
            end
            frame_err <= fe_set;
            overrun   <= push && full && !pop_req;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= pe_set;
            if (state == PARITY && tick) par_bad <= pe_set;
        end
    end
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (UART_DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (sh),
        .pop       (pop_req),
        .head      (rx_data),
        .empty     (empty),
        .full      (full)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit with a 4-entry FIFO.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       line;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_busy, frame_err, overrun, parity_err;

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
    int base;

    uart_rx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rx_wire (line),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_busy      (rx_busy),
        .frame_err    (frame_err),
        .overrun      (overrun),
        .parity_err   (parity_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err)  fe_cnt++;
        if (overrun)    ov_cnt++;
        if (parity_err) pe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        line = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic par, input logic stopv, input int stop_len);
        hold(1'b0, 16);
        for (int i = 0; i < 8; i++) hold(d[i], 16);
`ifdef UART_RX_PARITY_EN
        hold(par, 16);
`endif
        hold(stopv, stop_len);
    endtask

    task automatic send_ok(input logic [7:0] d);
        send(d, ^d, 1'b1, 16);
    endtask

    task automatic pop_exp(input string tag, input logic [7:0] exp);
        check({tag, " valid"}, 32'(rx_valid), 1);
        check({tag, " data"}, 32'(rx_data), 32'(exp));
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] c3;
        c3       = 8'hC3;
        rst      = 1'b0;
        line     = 1'b1;
        rx_ready = 1'b0;
        #12;
        check("reset valid", 32'(rx_valid), 0);
        check("reset data", 32'(rx_data), 0);
        check("reset busy", 32'(rx_busy), 0);
        check("reset errs", {29'd0, frame_err, overrun, parity_err}, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        hold(1'b1, 4);

        // Single byte, exact rx_valid latency relative to the stop-bit sample.
        send(8'hA5, ^8'hA5, 1'b1, 10);
        check("a5 valid early", 32'(rx_valid), 0);
        @(posedge clk);
        #1;
        check("a5 valid", 32'(rx_valid), 1);
        check("a5 data", 32'(rx_data), 32'h A5);
        hold(1'b1, 6);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        check("a5 popped", 32'(rx_valid), 0);
        check("a5 data held", 32'(rx_data), 32'hA5);

        // Fill the FIFO back-to-back, then overflow it by one.
        base = ov_cnt;
        send_ok(8'h01);
        send_ok(8'h80);
        send_ok(8'hFF);
        send_ok(8'h00);
        check("fill no overrun", 32'(ov_cnt - base), 0);
        send_ok(8'h55);
        hold(1'b1, 4);
        check("overrun once", 32'(ov_cnt - base), 1);
        pop_exp("pop0", 8'h01);
        pop_exp("pop1", 8'h80);
        pop_exp("pop2", 8'hFF);
        pop_exp("pop3", 8'h00);
        check("drained", 32'(rx_valid), 0);

        // Short low glitch on the line.
        base = fe_cnt;
        hold(1'b0, 4);
        check("glitch busy", 32'(rx_busy), 1);
        hold(1'b1, 10);
        check("glitch idle", 32'(rx_busy), 0);
        check("glitch no valid", 32'(rx_valid), 0);
        check("glitch no ferr", 32'(fe_cnt - base), 0);

        // Bad stop bit followed by a held-low line.
        base = fe_cnt;
        send(8'h3C, ^8'h3C, 1'b0, 56);
        check("ferr once", 32'(fe_cnt - base), 1);
        check("ferr no push", 32'(rx_valid), 0);
        check("break busy", 32'(rx_busy), 1);
        hold(1'b1, 4);
        check("break exit", 32'(rx_busy), 0);
        send_ok(8'h7E);
        pop_exp("after break", 8'h7E);
        check("after break drained", 32'(rx_valid), 0);

        // Asynchronous reset mid data bit 3.
        hold(1'b0, 16);
        for (int i = 0; i < 3; i++) hold(c3[i], 16);
        line = c3[3];
        repeat (8) @(posedge clk);
        #2;
        check("pre-reset busy", 32'(rx_busy), 1);
        rst = 1'b0;
        #1;
        check("async rst busy", 32'(rx_busy), 0);
        check("async rst valid", 32'(rx_valid), 0);
        check("async rst data", 32'(rx_data), 0);
        check("async rst errs", {29'd0, frame_err, overrun, parity_err}, 0);
        line = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        hold(1'b1, 4);
        send_ok(8'h5A);
        pop_exp("post reset", 8'h5A);
        check("post reset only one", 32'(rx_valid), 0);

`ifdef UART_RX_PARITY_EN
        base = pe_cnt;
        send(8'h07, 1'b0, 1'b1, 16);
        check("perr once", 32'(pe_cnt - base), 1);
        check("perr no push", 32'(rx_valid), 0);
        send(8'h07, 1'b1, 1'b1, 16);
        check("par good no perr", 32'(pe_cnt - base), 1);
        pop_exp("par good", 8'h07);
`else
        check("parity tied 0", 32'(pe_cnt), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
